// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop deserializer.
// Frames are sampled at bit centres using the baud generator's s_tick strobe.
module uart_rx #(
    parameter int unsigned DBIT    = 8,   // data bits per frame, 5..9
    parameter int unsigned SB_TICK = 16   // stop period in oversample ticks
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_rx,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_frame_err
);

    localparam int unsigned NW = $clog2(DBIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic            r_rx_meta, r_rx_s, r_rx_d;
    state_e          r_state, w_state;
    logic [4:0]      r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_b, w_b;
    logic [DBIT-1:0] r_dout, w_dout;
    logic            r_frame_err, w_frame_err;
    logic            r_done, w_done;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_s         <= '0;
            r_n         <= '0;
            r_b         <= '0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_s         <= w_s;
            r_n         <= w_n;
            r_b         <= w_b;
            r_dout      <= w_dout;
            r_frame_err <= w_frame_err;
            r_done      <= w_done;
        end
    end

    // Next-state and datapath update; nothing but the idle edge detect moves without s_tick.
    always_comb begin
        w_state     = r_state;
        w_s         = r_s;
        w_n         = r_n;
        w_b         = r_b;
        w_dout      = r_dout;
        w_frame_err = r_frame_err;
        w_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_rx_d && !r_rx_s) begin
                    w_s     = '0;
                    w_state = StStart;
                end
            end
            StStart: begin
                if (i_s_tick) begin
                    if (r_s == 5'd7) begin
                        if (!r_rx_s) begin
                            w_s     = '0;
                            w_n     = '0;
                            w_state = StData;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            w_state = StIdle;
                        end
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            StData: begin
                if (i_s_tick) begin
                    if (r_s == 5'd15) begin
                        w_s = '0;
                        w_b = {r_rx_s, r_b[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) begin
                            w_state = StStop;
                        end else begin
                            w_n = r_n + NW'(1);
                        end
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            StStop: begin
                if (i_s_tick) begin
                    if (r_s == 5'(SB_TICK - 1)) begin
                        w_dout      = r_b;
                        w_frame_err = ~r_rx_s;
                        w_done      = 1'b1;
                        w_state     = StIdle;
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        o_rx_done_tick = r_done;
        o_dout         = r_dout;
        o_frame_err    = r_frame_err;
    end

endmodule
